// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction of NOPS operands with valid/ready flow control and an output accumulator.
// Optional CSA_SAT_EN: widens the datapath and clamps the final result to the signed WIDTH range.
module csa_tree_pipe #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NOPS      = 9,
    parameter int unsigned REG_EVERY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NOPS*WIDTH-1:0] in_ops,
    input  logic                  in_acc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_sum,
    output logic                  out_ovf
);
    function automatic int unsigned count_after(int unsigned n, int unsigned layers);
        int unsigned m = n;
        for (int unsigned i = 0; i < layers; i++) m = m - m / 3;
        return m;
    endfunction

    function automatic int unsigned layers_for(int unsigned n);
        int unsigned m = n;
        int unsigned l = 0;
        for (int i = 0; i < 64; i++) begin
            if (m > 2) begin
                m = m - m / 3;
                l = l + 1;
            end
        end
        return l;
    endfunction

    function automatic int unsigned stages_for(int unsigned l, int unsigned r);
        if (r == 0) return 0;
        else return (l + r - 1) / r;
    endfunction

    function automatic bit is_boundary(int unsigned k, int unsigned l, int unsigned r);
        if (r == 0) return 1'b0;
        else return ((k % r) == 0) || (k == l);
    endfunction

    function automatic int unsigned stage_of(int unsigned k, int unsigned r);
        if (r == 0) return 0;
        else return (k + r - 1) / r - 1;
    endfunction

`ifdef CSA_SAT_EN
    localparam int unsigned G = $clog2(NOPS + 1) + 1;
`else
    localparam int unsigned G = 0;
`endif
    localparam int unsigned DW = WIDTH + G;
    localparam int unsigned L  = layers_for(NOPS);
    localparam int unsigned P  = stages_for(L, REG_EVERY);
    localparam int unsigned NF = count_after(NOPS, L);

    logic [P:0]    sv;
    logic [P:0]    up_v;
    logic [P:0]    ld;
    logic [DW-1:0] ops_ext [NOPS];
    logic [WIDTH-1:0] acc_reg;

    // Stage s may load when empty or when everything below it makes room this cycle.
    always_comb begin
        ld    = '0;
        ld[P] = ~sv[P] | out_ready;
        for (int s = int'(P) - 1; s >= 0; s--) ld[s] = ~sv[s] | ld[s+1];
    end

    assign in_ready  = ld[0];
    assign out_valid = sv[P];
    assign up_v      = (P+1)'({sv, in_valid});

    always_ff @(posedge clock) begin
        if (reset) begin
            sv <= '0;
        end else begin
            for (int s = 0; s <= int'(P); s++) begin
                if (ld[s]) sv[s] <= up_v[s];
            end
        end
    end

    for (genvar k = 0; k < NOPS; k++) begin : g_ext
        assign ops_ext[k] = DW'($signed(in_ops[k*WIDTH +: WIDTH]));
    end

    for (genvar j = 0; j < L; j++) begin : g_lay
        localparam int unsigned NI  = count_after(NOPS, j);
        localparam int unsigned NT  = NI / 3;
        localparam int unsigned NO  = NI - NT;
        localparam bit          REG = is_boundary(j + 1, L, REG_EVERY);
        localparam int unsigned STG = stage_of(j + 1, REG_EVERY);

        logic [DW-1:0] vi [NI];
        logic [DW-1:0] vo [NO];
        logic [DW-1:0] vn [NO];

        if (j == 0) begin : g_src
            assign vi = ops_ext;
        end else begin : g_src
            assign vi = g_lay[j-1].vn;
        end

        // 3:2 compress each triple; leftovers pass straight through.
        always_comb begin
            for (int k = 0; k < int'(NO); k++) vo[k] = '0;
            for (int t = 0; t < int'(NT); t++) begin
                vo[2*t]   = vi[3*t] ^ vi[3*t+1] ^ vi[3*t+2];
                vo[2*t+1] = ((vi[3*t] & vi[3*t+1]) | (vi[3*t] & vi[3*t+2])
                            | (vi[3*t+1] & vi[3*t+2])) << 1;
            end
            for (int r = 0; r < int'(NI - 3*NT); r++) vo[2*NT + r] = vi[3*NT + r];
        end

        if (REG) begin : g_reg
            logic [DW-1:0] q [NO];
            always_ff @(posedge clock) begin
                if (ld[STG] && up_v[STG]) q <= vo;
            end
            assign vn = q;
        end else begin : g_wire
            assign vn = vo;
        end
    end

    logic [DW-1:0] fin [NF];
    logic [DW-1:0] sum_vec;
    logic [DW-1:0] carry_vec;
    logic          fin_tag;

    if (L == 0) begin : g_fin
        assign fin = ops_ext;
    end else begin : g_fin
        assign fin = g_lay[L-1].vn;
    end

    assign sum_vec = fin[0];
    if (NF == 2) begin : g_c2
        assign carry_vec = fin[1];
    end else begin : g_c1
        assign carry_vec = '0;
    end

    // Accumulate flag rides alongside the carry-save stages.
    if (P == 0) begin : g_tag0
        assign fin_tag = in_acc;
    end else begin : g_tagp
        logic [P-1:0] tag_q;
        logic [P-1:0] tag_up;
        assign tag_up = P'({tag_q, in_acc});
        always_ff @(posedge clock) begin
            for (int s = 0; s < int'(P); s++) begin
                if (ld[s] && up_v[s]) tag_q[s] <= tag_up[s];
            end
        end
        assign fin_tag = tag_q[P-1];
    end

    logic [DW-1:0]    total;
    logic [WIDTH-1:0] res_sum;
    logic             res_ovf;

    assign total = sum_vec + carry_vec + (fin_tag ? DW'($signed(acc_reg)) : DW'(0));

`ifdef CSA_SAT_EN
    // Out of range when the guard bits plus the WIDTH sign bit disagree.
    assign res_ovf = !((&total[DW-1:WIDTH-1]) || !(|total[DW-1:WIDTH-1]));
    assign res_sum = !res_ovf      ? total[WIDTH-1:0] :
                     total[DW-1]   ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign res_ovf = 1'b0;
    assign res_sum = total[WIDTH-1:0];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            out_sum <= '0;
            out_ovf <= 1'b0;
            acc_reg <= '0;
        end else if (ld[P] && up_v[P]) begin
            out_sum <= res_sum;
            out_ovf <= res_ovf;
            acc_reg <= res_sum;
        end
    end
endmodule

// File: doc/csa_tree_pipe.md
Name: csa_tree_pipe

Overview:
- Parametrised, pipelined carry-save reduction tree: sums NOPS operands of WIDTH bits each.
- Built from 3:2 FA layers with a configurable register every REG_EVERY layers, followed by a registered final carry-propagate adder.
- Valid/ready handshake on input and output; optional running accumulation at the output stage.
- Sits between the MAC/partial-product arrays and the convolution output buffer; supersedes the fixed-count combinational CSA adders.

Parameters:
- WIDTH, 16, operand and result width in bits.
- NOPS, 9, number of operands, valid range 1..32.
- REG_EVERY, 2, FA layers per pipeline register; 0 means no intermediate registers.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept a vector.
- in_ops  in  NOPS*WIDTH  operand k at bits [k*WIDTH +: WIDTH], two's complement.
- in_acc  in  1  add the accumulator to this vector's sum.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result.
- out_ovf  out  1  result saturated (only with CSA_SAT_EN).

Behaviour:
- Single clock domain, named clock. Reset is synchronous and active-high, on port reset.
- Reset values: out_valid=0, out_sum=0, out_ovf=0, all stage valids=0, accumulator=0.
- in_ready is combinational from the stage state.
- Layer count: L(n)=0 for n<=2, otherwise L(n)=1+L(n-floor(n/3)). For NOPS=9, L=4 (9->6->4->3->2).
- Each layer groups its vectors into triples, 3:2 compresses each triple, and passes leftover vectors through unchanged.
- Each carry vector is shifted left by 1, and its MSB carry is discarded.
- Carry-save stage count: P = (REG_EVERY==0) ? 0 : ceil(L/REG_EVERY).
- Latency: P+1 cycles from accept (in_valid & in_ready) to out_valid. For the defaults, P=2 and latency is 3.
- NOPS=1 is a registered passthrough; NOPS=2 is a single registered add.
- Pipeline: P+1 register stages (CSA stages plus the output stage), each with its own valid bit. in_acc travels with the data.
- A stage loads when it is empty or when its downstream stage advances; bubbles collapse.
- The output stage advances when out_ready=1 or out_valid=0.
- in_ready = stage 0 empty, or stage 0 advancing in this cycle.
- Full pipeline with out_ready=0: in_ready=0. Up to P+1 vectors are held, with no loss and no reordering.
- Output arithmetic:
  - Final stage computes result = sum_vec + carry_vec + (acc_tag ? acc_reg : 0), modulo 2^WIDTH.
  - On every output-stage load, acc_reg <= result.
  - Starting a new accumulation group = sending in_acc=0.
- Simultaneous output accept and new load: the new result replaces out_sum in the same edge. out_valid stays 1.
- in_ops and in_acc are ignored when in_valid=0.
- Reset mid-operation: all in-flight vectors are discarded, acc_reg is cleared, and out_valid=0 on the cycle after the reset edge.

Optional Feature:
- Macro: CSA_SAT_EN.
- Defined:
  - Internal datapath width is WIDTH+G, with G=clog2(NOPS+1)+1. Operands are sign-extended, and acc_reg is held at WIDTH bits.
  - The final result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - out_ovf=1 for a result that was clamped; it is registered with out_sum.
  - acc_reg stores the clamped value.
- Undefined: WIDTH-bit wrap-around arithmetic, and out_ovf is tied to 0.

Test Plan:
- Defaults; in_ops = 1,2,...,9, in_acc=0, out_ready=1 -> out_sum=45 (0x002D) with out_valid exactly 3 cycles after accept.
- All nine operands 0xFFFF (-1), in_acc=0 -> out_sum=0xFFF7 (-9), out_ovf=0.
- Stream 6 back-to-back vectors with sums 1..6 while out_ready=0 for 8 cycles -> in_ready drops after 3 accepts. After release, outputs are 1,2,3,4,5,6 in order, with one result per cycle and none dropped.
- Three vectors with sums 10, 20, 30 and in_acc=0,1,1 -> outputs 10, 30, 60. A fourth vector with sum 7 and in_acc=0 -> 7.
- All operands 0x7FFF, in_acc=0:
  - Without macro: out_sum=0x7FF7, out_ovf=0.
  - With CSA_SAT_EN: out_sum=0x7FFF, out_ovf=1.
- Accept two vectors, assert reset for 1 cycle before any output -> out_valid=0 and no stale results appear. A following vector with sum 5 and in_acc=1 -> 5 (accumulator was cleared).
